// File: rtl/dram_req_bridge.sv
// Converts the arbiter-side toggle-store / pulse-load request into a single
// valid/ready word transaction, with lane placement, load extension and read timeout.
module dram_req_bridge #(
  parameter int unsigned MC_AW   = 27,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic [31:0]      w_dram_addr,
  input  logic [31:0]      w_dram_wdata,
  input  logic             w_dram_we_t,
  input  logic             w_dram_le,
  input  logic [2:0]       w_dram_ctrl,
  output logic             w_dram_busy,
  output logic [31:0]      w_dram_odata,
  output logic             w_dram_err,
  output logic             mc_req_valid,
  input  logic             mc_req_ready,
  output logic             mc_req_we,
  output logic [MC_AW-1:0] mc_req_addr,
  output logic [31:0]      mc_req_wdata,
  output logic [3:0]       mc_req_be,
  input  logic             mc_rsp_valid,
  input  logic [31:0]      mc_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              we_shadow_q, we_shadow_d;
  logic [MC_AW+1:0]  addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              is_st_q, is_st_d;
  logic              pend_rd_q, pend_rd_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [31:0]       odata_q, odata_d;
  logic              err_q, err_d;

  logic              wr_req, rd_req;
  logic [4:0]        sh;
  logic [31:0]       rsh;
  logic [31:0]       ld_data;
  logic              unused_addr_hi;

  function automatic logic req_ok(input logic [2:0] c, input logic [1:0] a);
    case (c)
      3'b000, 3'b100: req_ok = 1'b1;
      3'b001, 3'b101: req_ok = ~a[0];
      3'b010:         req_ok = (a == 2'b00);
      default:        req_ok = 1'b0;
    endcase
  endfunction

  assign unused_addr_hi = ^w_dram_addr[31:MC_AW+2];

  assign wr_req       = (w_dram_we_t != we_shadow_q);
  assign rd_req       = w_dram_le;
  assign w_dram_busy  = (state_q != IDLE) || wr_req || rd_req;
  assign w_dram_odata = odata_q;
  assign w_dram_err   = err_q;

  assign mc_req_valid = (state_q == ISSUE);
  assign mc_req_we    = is_st_q;
  assign mc_req_addr  = addr_q[MC_AW+1:2];
  assign sh           = {addr_q[1:0], 3'b000};
  assign rsh          = mc_rsp_rdata >> sh;

  always_comb begin
    mc_req_be    = 4'hF;
    mc_req_wdata = wdata_q;
    if (is_st_q) begin
      case (ctrl_q[1:0])
        2'b00: begin
          mc_req_be    = 4'b0001 << addr_q[1:0];
          mc_req_wdata = {24'h0, wdata_q[7:0]} << sh;
        end
        2'b01: begin
          mc_req_be    = 4'b0011 << addr_q[1:0];
          mc_req_wdata = {16'h0, wdata_q[15:0]} << sh;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ctrl_q)
      3'b000:  ld_data = {{24{rsh[7]}}, rsh[7:0]};
      3'b100:  ld_data = {24'h0, rsh[7:0]};
      3'b001:  ld_data = {{16{rsh[15]}}, rsh[15:0]};
      3'b101:  ld_data = {16'h0, rsh[15:0]};
      default: ld_data = rsh;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_shadow_d = we_shadow_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ctrl_d      = ctrl_q;
    is_st_d     = is_st_q;
    pend_rd_d   = pend_rd_q;
    tmo_d       = tmo_q;
    odata_d     = odata_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req || rd_req) begin
          addr_d  = w_dram_addr[MC_AW+1:0];
          ctrl_d  = w_dram_ctrl;
          is_st_d = wr_req;
          if (wr_req) begin
            wdata_d     = w_dram_wdata;
            we_shadow_d = w_dram_we_t;
          end
          if (req_ok(w_dram_ctrl, w_dram_addr[1:0])) begin
            state_d   = ISSUE;
            pend_rd_d = wr_req && rd_req;
          end else begin
            // a paired load shares the same addr/ctrl, so it is equally illegal
            state_d   = DONE;
            err_d     = 1'b1;
            pend_rd_d = 1'b0;
            if (rd_req) odata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (mc_req_ready) begin
          if (is_st_q) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            tmo_d   = '0;
          end
        end
      end
      WAIT: begin
        if (mc_rsp_valid) begin
          odata_d = ld_data;
          state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          odata_d = 32'hDEADBEEF;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      DONE: begin
        if (pend_rd_q) begin
          pend_rd_d = 1'b0;
          is_st_d   = 1'b0;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q     <= IDLE;
      we_shadow_q <= w_dram_we_t;
      is_st_q     <= 1'b0;
      pend_rd_q   <= 1'b0;
      tmo_q       <= '0;
      odata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_shadow_q <= we_shadow_d;
      is_st_q     <= is_st_d;
      pend_rd_q   <= pend_rd_d;
      tmo_q       <= tmo_d;
      odata_q     <= odata_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    ctrl_q  <= ctrl_d;
  end

endmodule

// File: tb/tb_dram_req_bridge.sv
// Bench for dram_req_bridge: directed vector table, randomized transactions against a
// byte-level reference model, and hand-written reset sequences.
module tb_dram_req_bridge;

  localparam int TMO = 16;
  localparam int LIMIT = 400;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic [31:0] w_dram_addr, w_dram_wdata;
  logic        w_dram_we_t, w_dram_le;
  logic [2:0]  w_dram_ctrl;
  logic        w_dram_busy, w_dram_err;
  logic [31:0] w_dram_odata;
  logic        mc_req_valid, mc_req_ready, mc_req_we;
  logic [26:0] mc_req_addr;
  logic [31:0] mc_req_wdata;
  logic [3:0]  mc_req_be;
  logic        mc_rsp_valid;
  logic [31:0] mc_rsp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  dram_req_bridge #(.MC_AW(27), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata),
    .w_dram_we_t(w_dram_we_t), .w_dram_le(w_dram_le), .w_dram_ctrl(w_dram_ctrl),
    .w_dram_busy(w_dram_busy), .w_dram_odata(w_dram_odata), .w_dram_err(w_dram_err),
    .mc_req_valid(mc_req_valid), .mc_req_ready(mc_req_ready), .mc_req_we(mc_req_we),
    .mc_req_addr(mc_req_addr), .mc_req_wdata(mc_req_wdata), .mc_req_be(mc_req_be),
    .mc_rsp_valid(mc_rsp_valid), .mc_rsp_rdata(mc_rsp_rdata)
  );

  typedef struct {
    logic        st, ld;
    logic [31:0] a, wd;
    logic [2:0]  c;
    logic [31:0] rd;
    int          rdy;
    bit          rsp;
    int          e_nreq, e_busy, e_err;
    logic        e_we;
    logic [26:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_od;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic st, logic ld, logic [31:0] a, logic [31:0] wd,
                              logic [2:0] c, logic [31:0] rd, int rdy, bit rsp,
                              int nreq, int busy, int err, logic we, logic [3:0] be,
                              logic [31:0] ewd, logic [31:0] od);
    vec_t v;
    v.st = st; v.ld = ld; v.a = a; v.wd = wd; v.c = c; v.rd = rd; v.rdy = rdy; v.rsp = rsp;
    v.e_nreq = nreq; v.e_busy = busy; v.e_err = err; v.e_we = we;
    v.e_addr = 27'(a / 4); v.e_be = be; v.e_wd = ewd; v.e_od = od;
    return v;
  endfunction

  // Reference model: access size in bytes, 0 for an illegal funct3.
  function automatic int size_of(input logic [2:0] c);
    case (c)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [2:0] c);
    int n, off;
    longint v;
    n = size_of(c);
    off = int'(a % 4);
    v = longint'(rd) / (longint'(1) << (8 * off));
    if (n < 4) begin
      v = v % (longint'(1) << (8 * n));
      if (c < 3'd4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    end
    return 32'(v);
  endfunction

  function automatic void model(inout vec_t v, inout logic [31:0] od);
    int n, off, r;
    bit ok;
    n = size_of(v.c);
    off = int'(v.a % 4);
    r = v.rdy;
    ok = 1'b0;
    if (n != 0) ok = ((v.a % n) == 0);
    v.e_addr = 27'(v.a / 4);
    v.e_we = v.st;
    v.e_be = 4'hF;
    v.e_wd = 32'h0;
    v.e_err = 0;
    v.e_nreq = 0;
    v.e_busy = 1;
    if (!ok) begin
      v.e_err = 1;
      if (v.ld) od = 32'h0;
    end else begin
      v.e_busy = 0;
      if (v.st) begin
        v.e_nreq++;
        v.e_busy += 2 + r;
        v.e_be = 4'(((1 << n) - 1) << off);
        v.e_wd = 32'((longint'(v.wd) % (longint'(1) << (8 * n))) * (longint'(1) << (8 * off)));
      end
      if (v.ld) begin
        v.e_nreq++;
        v.e_busy += 2 + r + (v.rsp ? 1 : TMO);
        if (v.rsp) od = load_val(v.rd, v.a, v.c);
        else begin
          od = 32'hDEADBEEF;
          v.e_err = 1;
        end
      end
    end
    v.e_od = od;
  endfunction

  // Drives one core request and plays the memory controller until busy drops.
  // Entered and left just after a falling edge.
  task automatic apply(input vec_t v, input string tag);
    int busy_n, nreq, nerr, vcyc;
    bit rsp_next, fin, snap;
    logic [63:0] snap_f;
    logic [63:0] r0_f;
    logic r1_we;
    logic [26:0] r1_addr;
    busy_n = 0; nreq = 0; nerr = 0; vcyc = 0; rsp_next = 0; fin = 0; snap = 0;
    snap_f = '0; r0_f = '0; r1_we = 1'b1; r1_addr = '0;
    w_dram_addr = v.a; w_dram_wdata = v.wd; w_dram_ctrl = v.c;
    if (v.st) w_dram_we_t = ~w_dram_we_t;
    w_dram_le = v.ld;
    for (int cyc = 0; cyc < LIMIT && !fin; cyc++) begin
      if (cyc > 0) w_dram_le = 1'b0;
      mc_rsp_valid = rsp_next;
      mc_rsp_rdata = rsp_next ? v.rd : $urandom;
      rsp_next = 0;
      #1;
      if (cyc == 0) chk({tag, ".busy_on_req"}, 32'(w_dram_busy), 32'd1);
      if (w_dram_err) nerr++;
      if (cyc > 0 && !w_dram_busy) fin = 1;
      else begin
        if (cyc > 0) busy_n++;
        if (mc_req_valid) begin
          if (!snap) begin
            snap_f = {mc_req_we, mc_req_addr, mc_req_be, mc_req_wdata};
            snap = 1;
          end else begin
            chk({tag, ".req_stable"},
                32'({mc_req_we, mc_req_addr, mc_req_be, mc_req_wdata} == snap_f), 32'd1);
          end
          mc_req_ready = (vcyc >= v.rdy);
          if (mc_req_ready) begin
            if (nreq == 0) r0_f = snap_f;
            else begin
              r1_we = mc_req_we;
              r1_addr = mc_req_addr;
            end
            nreq++;
            vcyc = 0;
            snap = 0;
            rsp_next = !mc_req_we && v.rsp;
          end else vcyc++;
        end else mc_req_ready = 1'($urandom_range(0, 1));
        @(negedge CLK);
      end
    end
    if (!fin) chk({tag, ".busy_release_timeout"}, 32'd0, 32'd1);
    chk({tag, ".nreq"}, 32'(nreq), 32'(v.e_nreq));
    chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(v.e_busy));
    chk({tag, ".err_pulses"}, 32'(nerr), 32'(v.e_err));
    chk({tag, ".odata"}, w_dram_odata, v.e_od);
    if (v.e_nreq > 0 && nreq > 0) begin
      chk({tag, ".we"}, 32'(r0_f[63]), 32'(v.e_we));
      chk({tag, ".addr"}, 32'(r0_f[62:36]), 32'(v.e_addr));
      chk({tag, ".be"}, 32'(r0_f[35:32]), 32'(v.e_be));
      if (v.e_we) chk({tag, ".wdata"}, r0_f[31:0], v.e_wd);
    end
    if (v.e_nreq > 1 && nreq > 1) begin
      chk({tag, ".load2_we"}, 32'(r1_we), 32'd0);
      chk({tag, ".load2_addr"}, 32'(r1_addr), 32'(v.e_addr));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [31:0] cur_od;
    int nvalid, nbusy;
    int legal_c[5] = '{0, 1, 2, 4, 5};

    RST_X = 1'b0; w_dram_we_t = 1'b1; w_dram_le = 1'b0;
    w_dram_addr = '0; w_dram_wdata = '0; w_dram_ctrl = '0;
    mc_req_ready = 1'b0; mc_rsp_valid = 1'b0; mc_rsp_rdata = '0;

    // Reset with we_t held high must not produce a store afterwards.
    repeat (3) @(negedge CLK);
    RST_X = 1'b1;
    #1;
    chk("reset.odata", w_dram_odata, 32'h0);
    chk("reset.busy", 32'(w_dram_busy), 32'd0);
    chk("reset.err", 32'(w_dram_err), 32'd0);
    nvalid = 0; nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      if (mc_req_valid) nvalid++;
      if (w_dram_busy) nbusy++;
    end
    chk("reset.quiet_valid", 32'(nvalid), 32'd0);
    chk("reset.quiet_busy", 32'(nbusy), 32'd0);
    chk("reset.quiet_odata", w_dram_odata, 32'h0);

    //              st ld addr     wdata         ctrl rdata         rdy rsp nreq busy err we be     ewd           odata
    tbl.push_back(mk(1, 0, 'h06, 'h1234ABCD, 3'd1, 'h0,          0, 1,  1,  2,  0, 1, 4'hC, 'hABCD0000, 'h0));
    tbl.push_back(mk(0, 1, 'h13, 'h0,        3'd0, 'h80FF7F01,   0, 1,  1,  3,  0, 0, 4'hF, 'h0,        'hFFFFFF80));
    tbl.push_back(mk(0, 1, 'h13, 'h0,        3'd4, 'h80FF7F01,   0, 1,  1,  3,  0, 0, 4'hF, 'h0,        'h00000080));
    tbl.push_back(mk(1, 1, 'h20, 'hCAFEF00D, 3'd2, 'h11223344,   0, 1,  2,  5,  0, 1, 4'hF, 'hCAFEF00D, 'h11223344));
    tbl.push_back(mk(0, 1, 'h22, 'h0,        3'd2, 'h55,         0, 1,  0,  1,  1, 0, 4'hF, 'h0,        'h0));
    tbl.push_back(mk(0, 1, 'h02, 'h0,        3'd5, 'h80010000,   5, 1,  1,  8,  0, 0, 4'hF, 'h0,        'h00008001));
    tbl.push_back(mk(1, 0, 'h07, 'hFFFFFF5A, 3'd0, 'h0,          2, 1,  1,  4,  0, 1, 4'h8, 'h5A000000, 'h00008001));
    tbl.push_back(mk(0, 1, 'h40, 'h0,        3'd2, 'h0,          0, 0,  1, 18,  1, 0, 4'hF, 'h0,        'hDEADBEEF));
    tbl.push_back(mk(1, 0, 'h00, 'h1,        3'd3, 'h0,          0, 1,  0,  1,  1, 1, 4'hF, 'h0,        'hDEADBEEF));
    tbl.push_back(mk(0, 1, 'h00, 'h0,        3'd6, 'h0,          0, 1,  0,  1,  1, 0, 4'hF, 'h0,        'h0));
    tbl.push_back(mk(0, 1, 'h02, 'h0,        3'd1, 'h80010000,   1, 1,  1,  4,  0, 0, 4'hF, 'h0,        'hFFFF8001));
    tbl.push_back(mk(1, 0, 'h01, 'h0000BEEF, 3'd1, 'h0,          0, 1,  0,  1,  1, 1, 4'hF, 'h0,        'hFFFF8001));
    tbl.push_back(mk(1, 0, 'h02, 'h0000BEEF, 3'd5, 'h0,          0, 1,  1,  2,  0, 1, 4'hC, 'hBEEF0000, 'hFFFF8001));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    cur_od = 32'hFFFF8001;
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 2);
      v.st = (op != 1);
      v.ld = (op != 0);
      v.a = $urandom_range(0, 255);
      v.wd = $urandom;
      v.rd = $urandom;
      v.c = 3'($urandom_range(0, 7));
      if (op == 2) begin
        v.c = 3'(legal_c[$urandom_range(0, 4)]);
        v.a = v.a - (v.a % size_of(v.c));
      end
      v.rdy = $urandom_range(0, 3);
      v.rsp = ($urandom_range(0, 9) != 0);
      model(v, cur_od);
      apply(v, $sformatf("rnd%0d", i));
    end

    // Reset while waiting for read data; a late response must be ignored.
    w_dram_addr = 32'h100; w_dram_ctrl = 3'd2; w_dram_le = 1'b1; mc_req_ready = 1'b1;
    mc_rsp_valid = 1'b0;
    @(negedge CLK); w_dram_le = 1'b0;
    @(negedge CLK); #1;
    chk("rstwait.in_wait_busy", 32'(w_dram_busy), 32'd1);
    chk("rstwait.in_wait_valid", 32'(mc_req_valid), 32'd0);
    @(negedge CLK); RST_X = 1'b0;
    @(negedge CLK); RST_X = 1'b1;
    #1;
    chk("rstwait.busy", 32'(w_dram_busy), 32'd0);
    chk("rstwait.valid", 32'(mc_req_valid), 32'd0);
    chk("rstwait.odata", w_dram_odata, 32'h0);
    mc_rsp_valid = 1'b1; mc_rsp_rdata = 32'h12345678;
    @(negedge CLK); mc_rsp_valid = 1'b0;
    #1;
    chk("rstwait.late_rsp_odata", w_dram_odata, 32'h0);
    chk("rstwait.late_rsp_busy", 32'(w_dram_busy), 32'd0);
    chk("rstwait.late_rsp_err", 32'(w_dram_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
